// File: rtl/arith_pkg.sv
// Shared types for the arithmetic capture stage: operand width, FSM encoding
// and the captured result bundle.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  typedef struct packed {
    logic [ARITH_WIDTH-1:0] sum;
    logic [ARITH_WIDTH-1:0] diff;
    logic [ARITH_WIDTH-1:0] prod;
    logic [ARITH_WIDTH-1:0] quot;
    logic [ARITH_WIDTH-1:0] rem;
    logic                   div_zero;
  } res_t;

endpackage

// File: rtl/arith_result_reg.sv
// Capture/hold register bank for the arithmetic unit results. Loads on
// 'load'; when the captured divisor was zero the quotient and remainder are
// forced to 0 so downstream never sees whatever the unit produced for x/0.
module arith_result_reg
  import arith_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   zero_div,
  input  logic [ARITH_WIDTH-1:0] y1,
  input  logic [ARITH_WIDTH-1:0] y2,
  input  logic [ARITH_WIDTH-1:0] y3,
  input  logic [ARITH_WIDTH-1:0] y4,
  input  logic [ARITH_WIDTH-1:0] y5,
  output res_t                   res
);

  // Result bank: loaded once per transaction, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
    end else if (load) begin
      res.sum      <= y1;
      res.diff     <= y2;
      res.prod     <= y3;
      res.quot     <= zero_div ? '0 : y4;
      res.rem      <= zero_div ? '0 : y5;
      res.div_zero <= zero_div;
    end
  end

endmodule

// File: rtl/arith_seq_capture.sv
// Sequential wrapper around the combinational arithmetic unit: accepts an
// operand pair, holds it on a/b for a settle window, captures the five
// results and presents them downstream. One transaction in flight at a time.
module arith_seq_capture
  import arith_pkg::*;
#(
  parameter int WIDTH         = ARITH_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     y1,
  input  logic [WIDTH-1:0]     y2,
  input  logic [WIDTH-1:0]     y3,
  input  logic [WIDTH-1:0]     y4,
  input  logic [WIDTH-1:0]     y5,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     r_sum,
  output logic [WIDTH-1:0]     r_diff,
  output logic [WIDTH-1:0]     r_prod,
  output logic [WIDTH-1:0]     r_quot,
  output logic [WIDTH-1:0]     r_rem,
  output logic                 div_zero,
  output logic [CNT_WIDTH-1:0] txn_count
);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       accept, capture, done;
  res_t       res;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == 4'd0) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers: change only on an accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (accept) begin
      a <= in_a;
      b <= in_b;
    end
  end

  // Settle window counter: loaded on accept, counts down while driving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   settle_cnt <= 4'd0;
    else if (accept)                              settle_cnt <= 4'(SETTLE_CYCLES - 1);
    else if (state == DRIVE && settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
  end

  // Output valid: raised by the capture cycle, dropped by the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       out_valid <= 1'b0;
    else if (capture) out_valid <= 1'b1;
    else if (done)    out_valid <= 1'b0;
  end

  // Completed-handshake counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    txn_count <= '0;
    else if (done) txn_count <= txn_count + CNT_WIDTH'(1);
  end

  arith_result_reg u_res (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .zero_div (b == '0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .y4       (y4),
    .y5       (y5),
    .res      (res)
  );

  assign r_sum    = res.sum;
  assign r_diff   = res.diff;
  assign r_prod   = res.prod;
  assign r_quot   = res.quot;
  assign r_rem    = res.rem;
  assign div_zero = res.div_zero;

endmodule

// File: tb/tb_arith_seq_capture.sv
// Bench for arith_seq_capture: main instance (SETTLE_CYCLES=1) checked every
// cycle against a transaction-level model, plus a SETTLE_CYCLES=4 /
// CNT_WIDTH=4 instance for settle-hold, latency and counter wrap.
module tb_arith_seq_capture;
  import arith_pkg::*;

  localparam int S  = 1;
  localparam int QS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic       in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [7:0] in_a, in_b, a, b, y1, y2, y3, y4, y5;
  logic [7:0] r_sum, r_diff, r_prod, r_quot, r_rem;
  logic [15:0] txn_count;

  // settle-4 / 4-bit counter instance
  logic       q_in_valid, q_in_ready, q_out_valid, q_out_ready, q_div_zero;
  logic [7:0] q_in_a, q_in_b, q_a, q_b, q_y1, q_y2, q_y3, q_y4, q_y5;
  logic [7:0] q_sum, q_diff, q_prod, q_quot, q_rem;
  logic [3:0] q_txn;

  // Arithmetic unit stand-ins; x/0 produces junk the stage must mask.
  assign y1 = a + b;
  assign y2 = a - b;
  assign y3 = a * b;
  assign y4 = (b == 8'd0) ? 8'hFF : a / b;
  assign y5 = (b == 8'd0) ? a : a % b;
  assign q_y1 = q_a + q_b;
  assign q_y2 = q_a - q_b;
  assign q_y3 = q_a * q_b;
  assign q_y4 = (q_b == 8'd0) ? 8'hFF : q_a / q_b;
  assign q_y5 = (q_b == 8'd0) ? q_a : q_a % q_b;

  arith_seq_capture #(.WIDTH(8), .SETTLE_CYCLES(S), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .a(a), .b(b),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_sum(r_sum), .r_diff(r_diff), .r_prod(r_prod), .r_quot(r_quot), .r_rem(r_rem),
    .div_zero(div_zero), .txn_count(txn_count)
  );

  arith_seq_capture #(.WIDTH(8), .SETTLE_CYCLES(QS), .CNT_WIDTH(4)) dut_q (
    .clk(clk), .rst_n(rst_n), .in_valid(q_in_valid), .in_ready(q_in_ready),
    .in_a(q_in_a), .in_b(q_in_b), .a(q_a), .b(q_b),
    .y1(q_y1), .y2(q_y2), .y3(q_y3), .y4(q_y4), .y5(q_y5),
    .out_valid(q_out_valid), .out_ready(q_out_ready),
    .r_sum(q_sum), .r_diff(q_diff), .r_prod(q_prod), .r_quot(q_quot), .r_rem(q_rem),
    .div_zero(q_div_zero), .txn_count(q_txn)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  bit rnd_bp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // What the stage must report for a given pair, from plain arithmetic.
  function automatic res_t expect_res(input logic [7:0] x, input logic [7:0] y);
    res_t r;
    r.sum      = 8'((int'(x) + int'(y)) % 256);
    r.diff     = 8'((int'(x) - int'(y) + 256) % 256);
    r.prod     = 8'((int'(x) * int'(y)) % 256);
    r.quot     = (y == 0) ? 8'd0 : 8'(int'(x) / int'(y));
    r.rem      = (y == 0) ? 8'd0 : 8'(int'(x) % int'(y));
    r.div_zero = (y == 0);
    return r;
  endfunction

  // Transaction model of the main instance: busy from accept until the
  // output handshake; results visible S+1 edges after the accept.
  bit          m_busy, m_hold;
  int          m_age;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_cnt;
  res_t        m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_hold = 0; m_age = 0;
      m_a = 0; m_b = 0; m_cnt = 0; m_res = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_age = 0; m_a = in_a; m_b = in_b;
      end
    end else if (m_hold) begin
      if (out_ready) begin
        m_busy = 0; m_hold = 0; m_cnt = m_cnt + 16'd1;
      end
    end else begin
      m_age++;
      if (m_age == S + 1) begin
        m_hold = 1;
        m_res  = expect_res(m_a, m_b);
      end
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_hold);
      chk("txn_count", txn_count, m_cnt);
      chk("a", a, m_a);
      chk("b", b, m_b);
      chk("r_sum", r_sum, m_res.sum);
      chk("r_diff", r_diff, m_res.diff);
      chk("r_prod", r_prod, m_res.prod);
      chk("r_quot", r_quot, m_res.quot);
      chk("r_rem", r_rem, m_res.rem);
      chk("div_zero", div_zero, m_res.div_zero);
    end
  end

  task automatic send(input logic [7:0] va, input logic [7:0] vb);
    int t = 0;
    @(negedge clk);
    in_valid = 1; in_a = va; in_b = vb;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      t++;
    end
    if (!in_ready) timeout("send_accept");
    @(posedge clk);
    #1;
    in_valid = 0; in_a = 8'($urandom); in_b = 8'($urandom);
  endtask

  // Directed pair with literal expectations and latency measurement.
  task automatic directed(input string nm, input logic [7:0] va, input logic [7:0] vb,
                          input int es, input int ed, input int ep, input int eq,
                          input int er, input int ez);
    int lat = 0;
    send(va, vb);
    while (lat < 50) begin
      @(posedge clk); lat++; #1;
      if (out_valid) break;
    end
    if (!out_valid) timeout({nm, "_valid"});
    chk({nm, "_latency"}, lat, S + 1);
    chk({nm, "_sum"}, r_sum, es);
    chk({nm, "_diff"}, r_diff, ed);
    chk({nm, "_prod"}, r_prod, ep);
    chk({nm, "_quot"}, r_quot, eq);
    chk({nm, "_rem"}, r_rem, er);
    chk({nm, "_dz"}, div_zero, ez);
  endtask

  task automatic q_send(input logic [7:0] va, input logic [7:0] vb, input int idx);
    int t = 0;
    int lat = 0;
    res_t r;
    @(negedge clk);
    q_in_valid = 1; q_in_a = va; q_in_b = vb;
    while (!q_in_ready && t < 100) begin @(negedge clk); t++; end
    if (!q_in_ready) timeout("q_accept");
    @(posedge clk);
    #1;
    q_in_valid = 0; q_in_a = 8'($urandom); q_in_b = 8'($urandom);
    while (lat < 50) begin
      @(posedge clk); lat++; #1;
      chk("q_hold_a", q_a, va);
      chk("q_hold_b", q_b, vb);
      chk("q_in_ready_busy", q_in_ready, 0);
      if (q_out_valid) break;
    end
    if (!q_out_valid) timeout("q_valid");
    chk("q_latency", lat, QS + 1);
    r = expect_res(va, vb);
    chk("q_sum", q_sum, r.sum);
    chk("q_quot", q_quot, r.quot);
    chk("q_rem", q_rem, r.rem);
    chk("q_dz", q_div_zero, r.div_zero);
    @(posedge clk);
    #1;
    chk("q_txn", q_txn, (idx + 1) % 16);
    chk("q_out_valid_drop", q_out_valid, 0);
  endtask

  initial begin
    int t;
    logic [7:0] ra, rb;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 1;
    q_in_valid = 0; q_in_a = 0; q_in_b = 0; q_out_ready = 1;

    // Reset state while held and just after release.
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_a", a, 0);
    chk("rst_r_sum", r_sum, 0);
    chk("rst_q_txn", q_txn, 0);
    #10 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_q_in_ready", q_in_ready, 1);
    chk_en = 1;

    // Directed arithmetic with literal results.
    directed("basic",   8'd8,   8'd4,   12,  4,  32, 2, 0, 0);
    directed("divzero", 8'd9,   8'd0,   9,   9,  0,  0, 0, 1);
    directed("wrap",    8'd200, 8'd100, 44,  100, 32, 2, 0, 0);
    directed("negdiff", 8'd4,   8'd8,   12,  252, 32, 0, 4, 0);
    directed("square",  8'd20,  8'd20,  40,  0,  144, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("txn_after_directed", txn_count, 5);

    // Backpressure with a second pair waiting.
    out_ready = 0;
    send(8'd7, 8'd3);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    if (!out_valid) timeout("bp_valid");
    @(negedge clk);
    in_valid = 1; in_a = 8'd5; in_b = 8'd2;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", r_sum, 10);
      chk("bp_prod", r_prod, 21);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_idle", in_ready, 1);
    chk("bp_txn", txn_count, 6);
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("bp_second_a", a, 5);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    if (!out_valid) timeout("bp_second_valid");
    chk("bp_second_sum", r_sum, 7);
    chk("bp_second_quot", r_quot, 2);

    // Randomized pairs with random downstream stalls.
    rnd_bp = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      send(ra, rb);
    end
    rnd_bp = 0;
    out_ready = 1;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) timeout("drain");

    // Asynchronous reset in the middle of DRIVE.
    send(8'd33, 8'd11);
    #3;
    rst_n = 0;
    #1;
    chk("mid_rst_a", a, 0);
    chk("mid_rst_b", b, 0);
    chk("mid_rst_txn", txn_count, 0);
    chk("mid_rst_sum", r_sum, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_txn", txn_count, 0);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end

    // Settle-4 instance: hold, latency, and 4-bit counter wrap.
    for (int i = 0; i < 17; i++) begin
      ra = 8'($urandom);
      rb = (i == 3) ? 8'd0 : 8'($urandom);
      q_send(ra, rb, i);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arith_seq_capture.md
Name: arith_seq_capture

Overview:
- Sequential front/back-end stage wrapped around the team's combinational 8-bit `arithmetic` unit.
- Accepts operand pairs over a valid/ready handshake and holds them stable on the unit's `a`/`b` inputs for a settle window.
- Captures the unit's five results (`y1` sum, `y2` difference, `y3` product, `y4` quotient, `y5` remainder) into registers and presents them downstream with a valid/ready handshake.
- Adds divide-by-zero detection and a transaction counter.

Parameters:
- WIDTH, 8: operand/result width; must match the arithmetic unit.
- SETTLE_CYCLES, 1: cycles operands are held before capture; legal range 1..15.
- CNT_WIDTH, 16: width of the transaction counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- a  output  WIDTH  registered operand A driven to the arithmetic unit.
- b  output  WIDTH  registered operand B driven to the arithmetic unit.
- y1..y5  input  WIDTH each  results returned from the arithmetic unit.
- out_valid  output  1  captured results valid.
- out_ready  input  1  downstream accepts results.
- r_sum, r_diff, r_prod, r_quot, r_rem  output  WIDTH each  captured y1..y5.
- div_zero  output  1  captured pair had b == 0.
- txn_count  output  CNT_WIDTH  number of completed output handshakes.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - a, b, all r_* outputs, div_zero, txn_count = 0.
  - out_valid = 0; in_ready = 1 once rst_n is released.
- FSM states: IDLE, DRIVE, CAPTURE, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge: a <= in_a, b <= in_b, settle counter <= SETTLE_CYCLES-1, go to DRIVE.
- DRIVE:
  - in_ready = 0; a and b held constant.
  - Counter decrements each cycle; on reaching 0, go to CAPTURE.
- CAPTURE (one cycle):
  - r_sum..r_rem <= y1..y5; div_zero <= (b == 0).
  - If b == 0: r_quot and r_rem are forced to 0, regardless of y4/y5.
  - out_valid <= 1; go to HOLD.
- HOLD:
  - out_valid = 1; all r_* and div_zero stable.
  - On out_valid && out_ready: out_valid <= 0, txn_count <= txn_count + 1, go to IDLE.
- Latency:
  - Accept edge k → out_valid high after edge k + SETTLE_CYCLES + 1.
  - Default SETTLE_CYCLES = 1: out_valid rises after edge k+2.
- Throughput: one pair per SETTLE_CYCLES + 3 cycles minimum, with out_ready tied high. There is no overlap of transactions.
- Width rules: results are the WIDTH-bit truncated values from the unit and are not re-computed here.
  - 200 + 100 → r_sum = 44.
  - 4 − 8 → r_diff = 252.
  - 20 * 20 → r_prod = 144.
- in_valid while in_ready = 0: ignored. Upstream must hold the pair until a handshake occurs.
- out_ready high outside HOLD: no effect.
- txn_count wraps from 2^CNT_WIDTH−1 to 0 silently.
- Reset mid-operation (any state):
  - Immediate return to IDLE with all outputs at reset values.
  - The in-flight transaction is discarded and not counted.
- a and b retain their last value in IDLE and HOLD; they change only on an accept.

Decomposition:
- Shared package `arith_pkg`:
  - WIDTH default.
  - FSM state encoding typedef (IDLE = 0, DRIVE = 1, CAPTURE = 2, HOLD = 3).
  - Result-bundle struct {sum, diff, prod, quot, rem, div_zero}.
- One natural sub-module: `arith_result_reg`. It is the capture/hold register bank with a load enable and a div-zero override.
- The FSM and counters stay in the top level.
- The `arithmetic` unit is instantiated outside this block; the bench instantiates both.

Test Plan:
- Basic:
  - Stimulus: in_a = 8, in_b = 4, out_ready = 1.
  - Response: r_sum = 12, r_diff = 4, r_prod = 32, r_quot = 2, r_rem = 0, div_zero = 0.
  - out_valid rises exactly SETTLE_CYCLES + 1 edges after the accept; txn_count = 1.
- Divide by zero:
  - Stimulus: in_a = 9, in_b = 0.
  - Response: div_zero = 1, r_quot = 0, r_rem = 0, r_sum = 9, r_diff = 9, r_prod = 0.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles after out_valid; a second pair is offered.
  - Response: in_ready = 0 throughout; results stable.
  - On out_ready = 1: one handshake, then IDLE; the second pair is accepted next.
- Overflow/wrap:
  - Stimulus: in_a = 200, in_b = 100.
  - Response: r_sum = 44, r_diff = 100, r_prod = 32, r_quot = 2, r_rem = 0.
  - Separately, preload txn_count to 0xFFFF via 65535 handshakes (or force), then complete one more: txn_count = 0.
- Reset mid-DRIVE:
  - Stimulus: assert rst_n = 0 asynchronously between clock edges during DRIVE.
  - Response: outputs go to 0 without waiting for clk; after release in_ready = 1 and txn_count = 0.
- SETTLE_CYCLES = 4 build:
  - Response: a and b held for 4 cycles; out_valid exactly 5 edges after the accept.
